// File: rtl/wb_queue.sv
// wb_queue: write-back buffer in front of the register file's single write port.
//
// Results from execute/memory are accepted over a valid/ready handshake and held
// in a small in-order circular FIFO. The FIFO drains at most one entry per cycle
// into the register file. Two combinational bypass ports search the queued
// entries, so decode still sees values that have not been committed yet.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready push handshake; in_addr/in_data form the pushed entry
//   hold              blocks draining this cycle (pushes still allowed)
//   wen/addrW/dataW   register file write port, driven from the head entry
//   q_addr1/q_addr2   bypass lookup addresses
//   hit1/hit2         a queued entry targets the lookup address
//   fwd1/fwd2         data of the youngest matching entry (0 when no hit)
//   count/empty       occupancy
module wb_queue #(
    parameter int unsigned wordLen = 16,
    parameter int unsigned addrLen = 3,
    parameter int unsigned depth   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [addrLen-1:0]       in_addr,
    input  logic [wordLen-1:0]       in_data,
    input  logic                     hold,
    output logic                     wen,
    output logic [addrLen-1:0]       addrW,
    output logic [wordLen-1:0]       dataW,
    input  logic [addrLen-1:0]       q_addr1,
    input  logic [addrLen-1:0]       q_addr2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [wordLen-1:0]       fwd1,
    output logic [wordLen-1:0]       fwd2,
    output logic [$clog2(depth):0]   count,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(depth);

    logic [addrLen-1:0] addr_mem_q [depth];
    logic [wordLen-1:0] data_mem_q [depth];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Handshake and write-port outputs depend only on registered state (plus
    // hold for wen), so in_ready has no path from in_valid or hold.
    always_comb begin
        in_ready = (count_q < DepthCnt);
        empty    = (count_q == '0);
        count    = count_q;
        wen      = !empty && !hold;
        push     = in_valid && in_ready;
        pop      = wen;
        addrW    = '0;
        dataW    = '0;
        if (!empty) begin
            addrW = addr_mem_q[head_q];
            dataW = data_mem_q[head_q];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + PtrW'(1);
        end
        if (push) begin
            tail_d = tail_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by head/count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q] <= in_addr;
            data_mem_q[tail_q] <= in_data;
        end
    end

    // Walk entries oldest to youngest; later matches overwrite earlier ones so
    // the youngest matching entry wins.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        fwd1 = '0;
        fwd2 = '0;
        for (int unsigned i = 0; i < depth; i++) begin
            idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if (addr_mem_q[idx] == q_addr1) begin
                    hit1 = 1'b1;
                    fwd1 = data_mem_q[idx];
                end
                if (addr_mem_q[idx] == q_addr2) begin
                    hit2 = 1'b1;
                    fwd2 = data_mem_q[idx];
                end
            end
        end
    end

endmodule
